// File: rtl/interm_layer_iter_pkg.sv
// Shared FSM encoding, reset level and helpers for the iterative min-sum layer.
// Tanner graph: edge e joins variable node e % N_V and check node e / CHK_DEG.
package interm_layer_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VAR  = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic RST_ACT = 1'b0;
  localparam int   CHK_DEG = 7;

  function automatic int eff_iter(input int n, input int max_n);
    if (n < 1) return 1;
    if (n > max_n) return max_n;
    return n;
  endfunction

  function automatic int sat(input int x, input int w);
    int lim;
    lim = (1 <<< (w - 1)) - 1;
    if (x > lim) return lim;
    if (x < -lim - 1) return -lim - 1;
    return x;
  endfunction

endpackage

// File: rtl/check_nodes.sv
// Offset min-sum check-node update with a per-edge bias.
module check_nodes
  import interm_layer_iter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int E     = 147,
  parameter int DEG   = CHK_DEG
) (
  input  logic [WIDTH*E-1:0] bias,
  input  logic [WIDTH*E-1:0] v_in,
  output logic [WIDTH*E-1:0] c_out
);

  localparam int MAG = (1 <<< (WIDTH - 1)) - 1;

  int   lo;
  int   j;
  int   x;
  int   mn;
  int   m;
  logic neg;

  always_comb begin
    lo = 0;
    j = 0;
    x = 0;
    mn = 0;
    m = 0;
    neg = 1'b0;
    c_out = '0;
    for (int e = 0; e < E; e++) begin
      lo = (e / DEG) * DEG;
      mn = MAG + 1;
      neg = 1'b0;
      for (int k = 0; k < DEG; k++) begin
        j = lo + k;
        if (j < E && j != e) begin
          x = int'($signed(v_in[WIDTH*j +: WIDTH]));
          neg = neg ^ (x < 0);
          if (x < 0) x = -x;
          if (x < mn) mn = x;
        end
      end
      m = mn - int'($signed(bias[WIDTH*e +: WIDTH]));
      if (m < 0) m = 0;
      else if (m > MAG) m = MAG;
      if (neg) m = -m;
      c_out[WIDTH*e +: WIDTH] = m[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/interm_layer_iter_bias_bank.sv
// Per-edge check-node bias registers, writable only while the layer is idle.
module interm_bias_bank
  import interm_layer_iter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int E     = 147,
  localparam int AW    = $clog2(E)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             idle,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH*E-1:0] bias
);

  logic [WIDTH-1:0] bank [E];
  logic             wr_ok;

  assign wr_ok = wr_en && idle && (int'(addr) < E);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      for (int i = 0; i < E; i++) bank[i] <= '0;
    end else if (wr_ok) begin
      bank[addr] <= data;
    end
  end

  for (genvar g = 0; g < E; g++) begin : g_flat
    assign bias[WIDTH*g +: WIDTH] = bank[g];
  end

endmodule

// File: rtl/variable_nodes.sv
// Variable-node update: channel LLR plus all other incoming edge messages.
module variable_nodes
  import interm_layer_iter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_V   = 44,
  parameter int E     = 147
) (
  input  logic [WIDTH*N_V-1:0] llr,
  input  logic [WIDTH*E-1:0]   msg,
  output logic [WIDTH*E-1:0]   v_out
);

  int tot [N_V];
  int s;

  // Full node sum first, then remove each edge's own message.
  always_comb begin
    s = 0;
    v_out = '0;
    for (int v = 0; v < N_V; v++)
      tot[v] = int'($signed(llr[WIDTH*v +: WIDTH]));
    for (int e = 0; e < E; e++)
      tot[e % N_V] += int'($signed(msg[WIDTH*e +: WIDTH]));
    for (int e = 0; e < E; e++) begin
      s = sat(tot[e % N_V]
            - int'($signed(msg[WIDTH*e +: WIDTH])), WIDTH);
      v_out[WIDTH*e +: WIDTH] = s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/interm_layer_iter.sv
// Sequential intermediate min-sum layer: one VAR and one CHK cycle per iteration,
// runtime iteration count, valid/ready in and out.
module interm_layer_iter
  import interm_layer_iter_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int N_V      = 44,
  parameter  int E        = 147,
  parameter  int MAX_ITER = 5,
  localparam int ITER_W   = $clog2(MAX_ITER + 1),
  localparam int AW       = $clog2(E)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ITER_W-1:0]    n_iter,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*N_V-1:0] all_llrs,
  input  logic [WIDTH*E-1:0]   prev_proc_elem,
  input  logic                 bias_wr_en,
  input  logic [AW-1:0]        bias_addr,
  input  logic [WIDTH-1:0]     bias_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH*E-1:0]   proc_elem,
  output logic [ITER_W-1:0]    iter_count,
  output logic                 busy
);

  localparam logic [ITER_W-1:0] ONE = ITER_W'(1);

  state_t               state;
  logic [WIDTH*N_V-1:0] llr_reg;
  logic [WIDTH*E-1:0]   msg_reg;
  logic [WIDTH*E-1:0]   v_reg;
  logic [WIDTH*E-1:0]   c_reg;
  logic [WIDTH*E-1:0]   v_nxt;
  logic [WIDTH*E-1:0]   c_nxt;
  logic [WIDTH*E-1:0]   bias;
  logic [ITER_W-1:0]    n_eff;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign proc_elem = c_reg;

  interm_bias_bank #(
    .WIDTH(WIDTH),
    .E    (E)
  ) u_bias (
    .clk  (clk),
    .rst  (rst),
    .wr_en(bias_wr_en),
    .idle (in_ready),
    .addr (bias_addr),
    .data (bias_data),
    .bias (bias)
  );

  variable_nodes #(
    .WIDTH(WIDTH),
    .N_V  (N_V),
    .E    (E)
  ) u_var (
    .llr  (llr_reg),
    .msg  (msg_reg),
    .v_out(v_nxt)
  );

  check_nodes #(
    .WIDTH(WIDTH),
    .E    (E)
  ) u_chk (
    .bias (bias),
    .v_in (v_reg),
    .c_out(c_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      state      <= ST_IDLE;
      llr_reg    <= '0;
      msg_reg    <= '0;
      v_reg      <= '0;
      c_reg      <= '0;
      iter_count <= '0;
      n_eff      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            llr_reg    <= all_llrs;
            msg_reg    <= prev_proc_elem;
            n_eff      <= ITER_W'(eff_iter(int'(n_iter), MAX_ITER));
            iter_count <= '0;
            state      <= ST_VAR;
          end
        end
        ST_VAR: begin
          v_reg <= v_nxt;
          state <= ST_CHK;
        end
        ST_CHK: begin
          c_reg      <= c_nxt;
          iter_count <= iter_count + ONE;
          if (iter_count + ONE == n_eff) begin
            state <= ST_DONE;
          end else begin
            msg_reg <= c_nxt;
            state   <= ST_VAR;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interm_layer_iter.sv
// Directed bench for interm_layer_iter: latency, clamping, bias bank,
// reset, backpressure and a randomised back-to-back stream.
module tb_interm_layer_iter;
  import interm_layer_iter_pkg::*;

  localparam int W    = 8;
  localparam int NV   = 44;
  localparam int NE   = 147;
  localparam int MAXI = 5;
  localparam int IW   = 3;
  localparam int AW   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [IW-1:0]   n_iter = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W*NV-1:0] all_llrs = '0;
  logic [W*NE-1:0] prev_proc_elem = '0;
  logic            bias_wr_en = 1'b0;
  logic [AW-1:0]   bias_addr = '0;
  logic [W-1:0]    bias_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W*NE-1:0] proc_elem;
  logic [IW-1:0]   iter_count;
  logic            busy;

  int checks = 0;
  int errors = 0;

  int g_llr  [NV];
  int g_msg  [NE];
  int g_bias [NE];
  logic [W*NE-1:0] exp_pe;

  logic [W*NE-1:0] q_pe [$];
  int              q_it [$];

  interm_layer_iter dut (
    .clk           (clk),
    .rst           (rst),
    .n_iter        (n_iter),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .all_llrs      (all_llrs),
    .prev_proc_elem(prev_proc_elem),
    .bias_wr_en    (bias_wr_en),
    .bias_addr     (bias_addr),
    .bias_data     (bias_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .proc_elem     (proc_elem),
    .iter_count    (iter_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clip(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > MAXI) return MAXI;
    return n;
  endfunction

  function automatic int first_diff(input logic [W*NE-1:0] a,
                                    input logic [W*NE-1:0] b);
    for (int e = 0; e < NE; e++)
      if (a[W*e +: W] !== b[W*e +: W]) return e;
    return 0;
  endfunction

  // Golden model: exclusive sums computed directly per edge.
  task automatic model(input int n);
    int m  [NE];
    int vv [NE];
    int s, c0, mn, a, mg;
    bit ng;
    m = g_msg;
    for (int it = 0; it < eff_n(n); it++) begin
      for (int e = 0; e < NE; e++) begin
        s = g_llr[e % NV];
        for (int f = e % NV; f < NE; f += NV)
          if (f != e) s += m[f];
        vv[e] = clip(s, -128, 127);
      end
      for (int e = 0; e < NE; e++) begin
        c0 = e - (e % CHK_DEG);
        ng = 1'b0;
        mn = 128;
        for (int f = c0; f < c0 + CHK_DEG && f < NE; f++)
          if (f != e) begin
            ng ^= (vv[f] < 0);
            a = (vv[f] < 0) ? -vv[f] : vv[f];
            if (a < mn) mn = a;
          end
        mg = clip(mn - g_bias[e], 0, 127);
        m[e] = ng ? -mg : mg;
      end
    end
    for (int e = 0; e < NE; e++) exp_pe[W*e +: W] = m[e][W-1:0];
  endtask

  task automatic set_flat(input int l, input int mval);
    for (int v = 0; v < NV; v++) g_llr[v] = l;
    for (int e = 0; e < NE; e++) g_msg[e] = mval;
  endtask

  task automatic set_pattern(input int seed);
    for (int v = 0; v < NV; v++)
      g_llr[v] = ((v * 37 + seed * 11) % 41) - 20;
    for (int e = 0; e < NE; e++)
      g_msg[e] = ((e * 13 + seed) % 23) - 11;
    g_llr[seed % NV] = 127;
    g_llr[(seed + 5) % NV] = -128;
    g_msg[(seed * 3) % NE] = -128;
  endtask

  task automatic load_inputs(input int n);
    for (int v = 0; v < NV; v++) all_llrs[W*v +: W] = g_llr[v][W-1:0];
    for (int e = 0; e < NE; e++) prev_proc_elem[W*e +: W] = g_msg[e][W-1:0];
    n_iter = IW'(n);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_cw(input int n, output int lat);
    int k;
    load_inputs(n);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    tick();
    in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic write_bias(input int addr, input int val);
    bias_wr_en = 1'b1;
    bias_addr  = AW'(addr);
    bias_data  = W'(val);
    tick();
    bias_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    for (int e = 0; e < NE; e++) g_bias[e] = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (proc_elem !== '0) begin
      errors++;
      $display("FAIL rst_proc_elem nonzero at edge %0d",
               first_diff(proc_elem, '0));
    end
    checks++;
    if (iter_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_iter got %0d want 0", iter_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
  endtask

  task automatic test_latency();
    int lat;
    set_flat(4, 0);
    run_cw(1, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL lat_n1 got %0d want 3", lat);
    end
    exp_pe = {NE{8'h04}};
    checks++;
    if (proc_elem !== exp_pe) begin
      errors++;
      $display("FAIL lat_result edge %0d got %0d want 4",
               first_diff(proc_elem, exp_pe),
               $signed(proc_elem[W*first_diff(proc_elem, exp_pe) +: W]));
    end
    checks++;
    if (iter_count !== 3'd1) begin
      errors++;
      $display("FAIL lat_iter got %0d want 1", iter_count);
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_release got rdy %b vld %b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_clamp();
    int lat;
    int d;
    set_pattern(1);
    model(0);
    run_cw(0, lat);
    checks++;
    if (lat !== 3 || iter_count !== 3'd1) begin
      errors++;
      $display("FAIL clamp_n0 got lat %0d iter %0d want 3 1",
               lat, iter_count);
    end
    checks++;
    if (proc_elem !== exp_pe) begin
      errors++;
      d = first_diff(proc_elem, exp_pe);
      $display("FAIL clamp_n0_data edge %0d got %0d want %0d", d,
               $signed(proc_elem[W*d +: W]), $signed(exp_pe[W*d +: W]));
    end
    release_out();
    set_pattern(2);
    model(7);
    run_cw(7, lat);
    checks++;
    if (lat !== 11 || iter_count !== 3'd5) begin
      errors++;
      $display("FAIL clamp_n7 got lat %0d iter %0d want 11 5",
               lat, iter_count);
    end
    checks++;
    if (proc_elem !== exp_pe) begin
      errors++;
      d = first_diff(proc_elem, exp_pe);
      $display("FAIL clamp_n7_data edge %0d got %0d want %0d", d,
               $signed(proc_elem[W*d +: W]), $signed(exp_pe[W*d +: W]));
    end
    release_out();
  endtask

  task automatic test_bias();
    int lat;
    write_bias(3, 2);
    g_bias[3] = 2;
    set_flat(4, 0);
    run_cw(1, lat);
    checks++;
    if (proc_elem[W*3 +: W] !== 8'sd2 || proc_elem[W*4 +: W] !== 8'sd4) begin
      errors++;
      $display("FAIL bias_e3 got %0d/%0d want 2/4",
               $signed(proc_elem[W*3 +: W]), $signed(proc_elem[W*4 +: W]));
    end
    release_out();
    write_bias(147, 9);
    run_cw(1, lat);
    exp_pe = {NE{8'h04}};
    exp_pe[W*3 +: W] = 8'h02;
    checks++;
    if (proc_elem !== exp_pe) begin
      errors++;
      $display("FAIL bias_oob edge %0d got %0d",
               first_diff(proc_elem, exp_pe),
               $signed(proc_elem[W*first_diff(proc_elem, exp_pe) +: W]));
    end
    release_out();
    load_inputs(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    write_bias(5, 3);
    wait_out(lat);
    checks++;
    if (proc_elem[W*5 +: W] !== 8'sd4) begin
      errors++;
      $display("FAIL bias_busy_wr got %0d want 4",
               $signed(proc_elem[W*5 +: W]));
    end
    release_out();
    bias_wr_en = 1'b1;
    bias_addr  = 8'd10;
    bias_data  = 8'sd1;
    in_valid   = 1'b1;
    tick();
    bias_wr_en = 1'b0;
    in_valid   = 1'b0;
    g_bias[10] = 1;
    wait_out(lat);
    checks++;
    if (proc_elem[W*10 +: W] !== 8'sd3 || proc_elem[W*5 +: W] !== 8'sd4) begin
      errors++;
      $display("FAIL bias_wr_accept got %0d/%0d want 3/4",
               $signed(proc_elem[W*10 +: W]), $signed(proc_elem[W*5 +: W]));
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    set_pattern(3);
    load_inputs(5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state got busy %b rdy %b vld %b want 0 1 0",
               busy, in_ready, out_valid);
    end
    tick();
    rst = 1'b1;
    for (int e = 0; e < NE; e++) g_bias[e] = 0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || proc_elem !== '0) begin
      errors++;
      $display("FAIL rstmid_no_out got pulse %b want 0", seen);
    end
    set_flat(4, 0);
    run_cw(1, lat);
    checks++;
    if (proc_elem[W*3 +: W] !== 8'sd4 || proc_elem[W*10 +: W] !== 8'sd4) begin
      errors++;
      $display("FAIL rst_bias_clear got %0d/%0d want 4/4",
               $signed(proc_elem[W*3 +: W]), $signed(proc_elem[W*10 +: W]));
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    int d;
    bit stable;
    logic [W*NE-1:0] snap;
    set_pattern(4);
    model(2);
    run_cw(2, lat);
    checks++;
    if (lat !== 5 || proc_elem !== exp_pe) begin
      errors++;
      d = first_diff(proc_elem, exp_pe);
      $display("FAIL bp_first lat %0d want 5 edge %0d got %0d want %0d",
               lat, d, $signed(proc_elem[W*d +: W]),
               $signed(exp_pe[W*d +: W]));
    end
    snap = proc_elem;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (proc_elem !== snap || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got stable %b want 1", stable);
    end
    set_pattern(5);
    load_inputs(3);
    in_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || iter_count !== 3'd2) begin
      errors++;
      $display("FAIL bp_no_accept got vld %b iter %0d want 1 2",
               out_valid, iter_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle got rdy %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept got busy %b want 1", busy);
    end
    model(3);
    wait_out(lat);
    checks++;
    if (lat !== 7 || proc_elem !== exp_pe) begin
      errors++;
      d = first_diff(proc_elem, exp_pe);
      $display("FAIL bp_second lat %0d want 7 edge %0d got %0d want %0d",
               lat, d, $signed(proc_elem[W*d +: W]),
               $signed(exp_pe[W*d +: W]));
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int got;
    int cyc;
    int d;
    int a;
    int it;
    bit extra;
    logic [W*NE-1:0] e_pe;
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, NE - 1);
      d = $urandom_range(0, 3);
      write_bias(a, d);
      g_bias[a] = d;
    end
    write_bias(0, -2);
    g_bias[0] = -2;
    got = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int n;
          int k;
          n = $urandom_range(0, 7);
          for (int v = 0; v < NV; v++)
            g_llr[v] = int'($signed(8'($urandom)));
          for (int e = 0; e < NE; e++)
            g_msg[e] = int'($signed(8'($urandom)));
          model(n);
          load_inputs(n);
          in_valid = 1'b1;
          k = 0;
          while (!in_ready && k < 100) begin
            tick();
            k++;
          end
          q_pe.push_back(exp_pe);
          q_it.push_back(eff_n(n));
          tick();
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        cyc = 0;
        while (got < 20 && cyc < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            checks++;
            if (q_pe.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra result %0d with empty queue", got);
            end else begin
              e_pe = q_pe.pop_front();
              it = q_it.pop_front();
              if (proc_elem !== e_pe || iter_count !== IW'(it)) begin
                errors++;
                d = first_diff(proc_elem, e_pe);
                $display("FAIL b2b_%0d edge %0d got %0d want %0d iter %0d want %0d",
                         got, d, $signed(proc_elem[W*d +: W]),
                         $signed(e_pe[W*d +: W]), iter_count, it);
              end
            end
            got++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (got !== 20 || q_pe.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count got %0d left %0d want 20 0", got, q_pe.size());
    end
    out_ready = 1'b1;
    extra = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) extra = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL b2b_dup got out_valid %b want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clamp();
    test_bias();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interm_layer_iter.md
Name: interm_layer_iter

Overview:
Sequential, parametrised successor of the combinational intermediate min-sum layer. It accepts one codeword's channel LLRs and initial edge messages over a valid/ready handshake. It then runs a runtime-selectable number of variable-node/check-node iterations, registering the result after each half-iteration. The per-edge check-node bias comes from an internal writable register bank. It sits between the input layer and the output/marginalisation layer of the unrolled decoder.

Parameters:
WIDTH, 8, signed two's-complement width of every LLR, message and bias
N_V, 44, number of variable nodes (channel LLRs)
E, 147, number of Tanner-graph edges
MAX_ITER, 5, maximum iterations per codeword (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
n_iter  in  ITER_W=$clog2(MAX_ITER+1)  requested iterations, sampled on input accept
in_valid  in  1  all_llrs/prev_proc_elem valid
in_ready  out  1  block can accept a codeword
all_llrs  in  WIDTH*N_V  channel LLRs, node v at [WIDTH*v +: WIDTH]
prev_proc_elem  in  WIDTH*E  initial edge messages, edge e at [WIDTH*e +: WIDTH]
bias_wr_en  in  1  bias write strobe
bias_addr  in  $clog2(E)  edge index to write
bias_data  in  WIDTH  bias value
out_valid  out  1  proc_elem holds a finished result
out_ready  in  1  downstream accepts result
proc_elem  out  WIDTH*E  registered check-node output
iter_count  out  ITER_W  iterations completed on current codeword
busy  out  1  state != IDLE

Behaviour:
- Reset: rst==0 acts asynchronously. It forces state IDLE, clears all data and bias registers, and sets iter_count=0 and out_valid=0. proc_elem is 0 and in_ready is 1 once reset is released. Reset mid-operation aborts the codeword; no output is produced.
- FSM states: IDLE, VAR, CHK, DONE. Outputs are decoded from registered state: in_ready = (IDLE), out_valid = (DONE), busy = !(IDLE).
- IDLE: on in_valid, latch all_llrs into llr_reg and prev_proc_elem into msg_reg. Latch the effective iteration count: n_iter==0 is treated as 1, and n_iter>MAX_ITER is clamped to MAX_ITER. Clear iter_count, then go to VAR.
- VAR (1 cycle): v_reg <= variable_nodes(llr_reg, msg_reg). Go to CHK.
- CHK (1 cycle): c_reg <= check_nodes(bias_bank, v_reg) and iter_count increments.
  - If iter_count+1 == effective count, go to DONE.
  - Otherwise msg_reg <= check-node result and go to VAR.
- DONE: hold c_reg on proc_elem while out_valid stays 1. On out_ready, go to IDLE. in_valid in the same cycle is NOT accepted, so there is at least one bubble between codewords.
- Latency: the accept edge is cycle 0, and out_valid rises after 2*N+1 edges (N = effective iterations). N=1 gives 3 cycles; N=5 gives 11 cycles.
- Backpressure: DONE holds indefinitely and proc_elem stays stable while out_valid=1 and out_ready=0.
- Bias bank:
  - A write completes on the clock edge where bias_wr_en=1, bias_addr<E and state==IDLE.
  - A write is ignored if bias_addr>=E or the state is not IDLE; bias stays frozen during a codeword.
  - A write and an input accept in the same IDLE cycle are both taken, and the new bias applies to that codeword.
- Arithmetic: width and saturation rules are those of variable_nodes/check_nodes. This block adds no arithmetic and does no width growth.
- in_valid while busy is ignored. The sender must hold data until in_ready.

Decomposition:
- ct.vh gains the FSM state encodings (IDLE/VAR/CHK/DONE, 2 bits) and an active-low reset-level macro.
- Existing variable_nodes and check_nodes are instantiated unchanged.
- One natural sub-module, interm_bias_bank: holds E x WIDTH registers with address decode, the IDLE write gate and async clear, and outputs the flat WIDTH*E bias vector.

Test Plan:
- Reset then idle: release rst -> in_ready=1, out_valid=0, proc_elem=0, iter_count=0. Assert rst=0 mid-VAR -> next cycle state IDLE and no out_valid pulse.
- Latency: n_iter=1, all_llrs all 8'sd4, prev_proc_elem=0, bias=0 -> out_valid exactly 3 cycles after accept. proc_elem equals the golden model of one iteration and iter_count=1.
- Clamp: n_iter=0 -> 3-cycle latency. n_iter=7 with MAX_ITER=5 -> 11-cycle latency and iter_count=5.
- Bias:
  - Write bias_addr=3, bias_data=8'sd2 in IDLE -> edge 3 result matches golden model with bias 2.
  - Write bias_addr=147 -> no register changes.
  - Write during VAR -> ignored, and the result uses the old bias.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> proc_elem and out_valid are stable. Drive in_valid=1 during DONE -> not accepted. Raise out_ready -> IDLE next cycle, and the held in_valid is accepted then.
- Back-to-back: 20 random codewords with random n_iter and random out_ready -> every result matches the golden model in order, with none dropped or duplicated.
